// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, access-size codes and alignment helper for
//                the load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Size code 3 has no legal alignment, so it always reports misaligned.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
      logic w_ok;
      w_ok = 1'b0;
      case (size)
         SZ_BYTE: w_ok = 1'b1;
         SZ_HALF: w_ok = ~addr[0];
         SZ_WORD: w_ok = (addr == 2'b00);
         default: w_ok = 1'b0;
      endcase
      return w_ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lsu_lane
//  Description : Little-endian lane steering. Extracts and extends a load
//                value from a memory word, and merges store data into the
//                same word for read-modify-write.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and halfword lanes.
   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
   end

   // Right-align the lane and extend; word loads pass through untouched.
   always_comb begin
      o_load = i_word;
      case (i_size)
         SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load = i_word;
      endcase
   end

   // Replace only the addressed lane; upper store-data bits are dropped.
   always_comb begin
      o_merge = i_word;
      case (i_size)
         SZ_BYTE: begin
            case (i_addr)
               2'd0: o_merge[7:0]   = i_wdata[7:0];
               2'd1: o_merge[15:8]  = i_wdata[7:0];
               2'd2: o_merge[23:16] = i_wdata[7:0];
               2'd3: o_merge[31:24] = i_wdata[7:0];
               default: o_merge = i_word;
            endcase
         end
         SZ_HALF: begin
            if (i_addr[1]) o_merge[31:16] = i_wdata[15:0];
            else           o_merge[15:0]  = i_wdata[15:0];
         end
         default: o_merge = i_wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding CPU load/store front end for a
//                word-addressed SRAM without byte enables. Sub-word stores
//                are read-modify-write; misaligned accesses never reach
//                memory.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int READ_LAT = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q
);

   // Last RD cycle index; counter runs 0 .. READ_LAT-1.
   localparam logic [1:0] c_LAST = 2'(READ_LAT - 1);

   lsu_state_t  r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [1:0]  r_lo;
   logic [31:0] r_wdata;
   logic [1:0]  r_cnt;

   logic [31:0] w_load;
   logic [31:0] w_merge;

   // The lane unit always looks at the live read word so the value is
   // ready on the same edge that closes the last RD cycle.
   lsu_lane u_lane (
      .i_word   (mem_q),
      .i_addr   (r_lo),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   assign req_ready  = rst && (r_state == IDLE);
   assign mem_wren   = (r_state == WR);
   assign resp_valid = (r_state == RESP);

   // Request sequencing: accept, optional read phase, optional write, respond.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state         <= IDLE;
         r_we            <= 1'b0;
         r_size          <= SZ_BYTE;
         r_signed        <= 1'b0;
         r_lo            <= 2'd0;
         r_wdata         <= '0;
         r_cnt           <= '0;
         mem_addr        <= '0;
         mem_data        <= '0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_lo     <= req_addr[1:0];
                  r_wdata  <= req_wdata;
                  r_cnt    <= '0;
                  mem_addr <= req_addr[31:2];
                  if (!is_aligned(req_size, req_addr[1:0])) begin
                     resp_misaligned <= 1'b1;
                     resp_rdata      <= '0;
                     r_state         <= RESP;
                  end else if (req_we && (req_size == SZ_WORD)) begin
                     resp_misaligned <= 1'b0;
                     mem_data        <= req_wdata;
                     r_state         <= WR;
                  end else begin
                     resp_misaligned <= 1'b0;
                     r_state         <= RD;
                  end
               end
            end
            RD: begin
               if (r_cnt == c_LAST) begin
                  if (r_we) begin
                     mem_data <= w_merge;
                     r_state  <= WR;
                  end else begin
                     resp_rdata <= w_load;
                     r_state    <= RESP;
                  end
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            WR: begin
               resp_rdata <= '0;
               r_state    <= RESP;
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a
//                transaction-level reference model and SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   localparam int RL = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [29:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q = '0;

   always #5 clk = ~clk;

   load_store_unit #(.READ_LAT(RL)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_size        (req_size),
      .req_signed      (req_signed),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .mem_wren        (mem_wren),
      .mem_q           (mem_q)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // SRAM contents; untouched words read back as an address-derived pattern.
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] mrd(input logic [29:0] a);
      if (mem.exists(a)) return mem[a];
      return {a, 2'b00} ^ 32'h5A5A_C3C3;
   endfunction

   // Byte-wise lane extraction with optional extension from the lane MSB.
   function automatic logic [31:0] ext(input logic [31:0] w, input int lo, input int nb, input bit sg);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nb; i++)
         v = v | (((w >> (8 * (lo + i))) & 32'hFF) << (8 * i));
      if (sg && nb < 4 && v[8 * nb - 1])
         v = v | (32'hFFFF_FFFF << (8 * nb));
      return v;
   endfunction

   // Byte-wise replacement of nb bytes starting at lane lo.
   function automatic logic [31:0] mrg(input logic [31:0] w, input int lo, input int nb, input logic [31:0] wd);
      logic [31:0] v;
      v = w;
      for (int i = 0; i < nb; i++) begin
         v = v & ~(32'hFF << (8 * (lo + i)));
         v = v | (((wd >> (8 * i)) & 32'hFF) << (8 * (lo + i)));
      end
      return v;
   endfunction

   // Reference model: one transaction in flight, cycle n counted from accept.
   int          cyc = 0;
   bit          m_busy = 0;
   int          m_n = 0;
   int          m_resp_cyc = 0;
   int          m_wr_cyc = 0;
   bit          m_mis = 0;
   logic [29:0] m_addr = '0;
   logic [31:0] m_rdata = '0;
   logic [31:0] m_wdat = '0;
   logic [31:0] m_rdata_out = '0;
   int          m_nb, m_lo;
   logic [31:0] m_w;
   int          acc_cnt = 0;
   int          acc_cyc_q[$];

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         m_busy      = 0;
         m_addr      = '0;
         m_rdata_out = '0;
      end else if (m_busy) begin
         if (m_n == m_resp_cyc) m_busy = 0;
         else                   m_n++;
      end else if (req_valid) begin
         m_nb     = 1 << req_size;
         m_lo     = int'(req_addr[1:0]);
         m_mis    = (req_size == 2'd3) || ((m_lo % m_nb) != 0);
         m_addr   = req_addr[31:2];
         m_w      = mrd(m_addr);
         m_wr_cyc = 0;
         m_rdata  = '0;
         m_wdat   = '0;
         if (m_mis) begin
            m_resp_cyc = 1;
         end else if (req_we && m_nb == 4) begin
            m_wr_cyc   = 1;
            m_resp_cyc = 2;
            m_wdat     = req_wdata;
         end else if (!req_we) begin
            m_resp_cyc = RL + 1;
            m_rdata    = ext(m_w, m_lo, m_nb, req_signed);
         end else begin
            m_wr_cyc   = RL + 1;
            m_resp_cyc = RL + 2;
            m_wdat     = mrg(m_w, m_lo, m_nb, req_wdata);
         end
         m_busy = 1;
         m_n    = 1;
         acc_cnt++;
         acc_cyc_q.push_back(cyc);
      end
      if (m_busy && m_n == m_resp_cyc) m_rdata_out = m_rdata;
   end

   // Read data is only valid once the address has been up READ_LAT cycles.
   always @(negedge clk) begin
      if (m_busy && m_n >= RL) mem_q = mrd(m_addr);
      else                     mem_q = $urandom();
   end

   // Observations of DUT pulses for the directed literal checks.
   int          wr_cnt = 0, resp_cnt = 0;
   int          last_wr_n = -1, last_resp_n = -1;
   logic [31:0] last_wr_data = '0, last_rdata = '0;
   logic [29:0] last_wr_addr = '0;
   logic        last_mis = 1'b0;
   logic [31:0] resp_q[$];

   // Compare every cycle, one time unit after the active edge.
   always @(posedge clk) begin
      #1;
      chk("req_ready", 32'(req_ready), 32'(rst && !m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_n == m_resp_cyc));
      chk("mem_wren", 32'(mem_wren), 32'(m_busy && m_n == m_wr_cyc));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("resp_rdata", resp_rdata, m_rdata_out);
      if (!rst) begin
         chk("rst_mem_data", mem_data, 32'h0);
         chk("rst_misaligned", 32'(resp_misaligned), 32'h0);
      end
      if (m_busy && m_n == m_wr_cyc)
         chk("mem_data", mem_data, m_wdat);
      if (m_busy && m_n == m_resp_cyc)
         chk("resp_misaligned", 32'(resp_misaligned), 32'(m_mis));
      if (mem_wren === 1'b1) begin
         mem[mem_addr] = mem_data;
         wr_cnt++;
         last_wr_n    = m_n;
         last_wr_data = mem_data;
         last_wr_addr = mem_addr;
      end
      if (resp_valid === 1'b1) begin
         resp_cnt++;
         last_resp_n = m_n;
         last_rdata  = resp_rdata;
         last_mis    = resp_misaligned;
         resp_q.push_back(resp_rdata);
      end
   end

   // Present a request and hold it until the model sees it accepted.
   task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
      int start;
      int k;
      start = acc_cnt;
      k = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      while (acc_cnt == start && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (acc_cnt == start) chk("accept_timeout", 32'(k), 32'(0));
      req_valid  = hold;
      req_we     = 1'($urandom());
      req_size   = 2'($urandom());
      req_signed = 1'($urandom());
      req_addr   = $urandom();
      req_wdata  = $urandom();
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (m_busy && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (m_busy) chk("idle_timeout", 32'(k), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, a0;
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;

      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Word store
      w0 = wr_cnt; r0 = resp_cnt;
      issue(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      wait_idle();
      chk("ws_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("ws_wr_cycle", 32'(last_wr_n), 32'd1);
      chk("ws_wr_addr", 32'(last_wr_addr), 32'h4);
      chk("ws_wr_data", last_wr_data, 32'hDEAD_BEEF);
      chk("ws_resp_cycle", 32'(last_resp_n), 32'd2);
      chk("ws_resp_mis", 32'(last_mis), 32'd0);
      chk("ws_resp_count", 32'(resp_cnt - r0), 32'd1);

      // Byte loads from 0x80FF7F01
      mem[30'h100] = 32'h80FF_7F01;
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0401, 32'h0, 1'b0); wait_idle();
      chk("lb_01_data", last_rdata, 32'h0000_007F);
      chk("lb_01_cycle", 32'(last_resp_n), 32'(RL + 1));
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0402, 32'h0, 1'b0); wait_idle();
      chk("lb_10_data", last_rdata, 32'hFFFF_FFFF);
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0403, 32'h0, 1'b0); wait_idle();
      chk("lb_11s_data", last_rdata, 32'hFFFF_FF80);
      issue(1'b0, 2'd0, 1'b0, 32'h0000_0403, 32'h0, 1'b0); wait_idle();
      chk("lb_11u_data", last_rdata, 32'h0000_0080);
      chk("lb_11u_cycle", 32'(last_resp_n), 32'(RL + 1));

      // Half store RMW
      mem[30'h200] = 32'h1122_3344;
      w0 = wr_cnt;
      issue(1'b1, 2'd1, 1'b0, 32'h0000_0802, 32'hAAAA_BEEF, 1'b0);
      wait_idle();
      chk("hs_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("hs_wr_data", last_wr_data, 32'hBEEF_3344);
      chk("hs_wr_cycle", 32'(last_wr_n), 32'(RL + 1));
      chk("hs_resp_cycle", 32'(last_resp_n), 32'(RL + 2));

      // Misaligned accesses
      w0 = wr_cnt;
      issue(1'b1, 2'd2, 1'b0, 32'h0000_0806, 32'h1234_5678, 1'b0); wait_idle();
      chk("mis_w_flag", 32'(last_mis), 32'd1);
      chk("mis_w_data", last_rdata, 32'h0);
      chk("mis_w_cycle", 32'(last_resp_n), 32'd1);
      issue(1'b0, 2'd1, 1'b1, 32'h0000_0801, 32'h0, 1'b0); wait_idle();
      chk("mis_h_flag", 32'(last_mis), 32'd1);
      chk("mis_h_data", last_rdata, 32'h0);
      chk("mis_h_cycle", 32'(last_resp_n), 32'd1);
      issue(1'b1, 2'd3, 1'b0, 32'h0000_0800, 32'hFFFF_FFFF, 1'b0); wait_idle();
      chk("mis_3_flag", 32'(last_mis), 32'd1);
      chk("mis_3_data", last_rdata, 32'h0);
      chk("mis_3_cycle", 32'(last_resp_n), 32'd1);
      chk("mis_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("mis_mem_intact", mrd(30'h200), 32'hBEEF_3344);

      // Reset during the read phase of a byte RMW
      w0 = wr_cnt; r0 = resp_cnt;
      mem[30'h201] = 32'hCAFE_F00D;
      issue(1'b1, 2'd0, 1'b0, 32'h0000_0805, 32'h0000_0055, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rr_ready_low", 32'(req_ready), 32'd0);
      rst = 1'b1;
      repeat (RL + 4) @(negedge clk);
      chk("rr_ready_high", 32'(req_ready), 32'd1);
      chk("rr_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("rr_no_resp", 32'(resp_cnt - r0), 32'd0);
      chk("rr_mem_intact", mrd(30'h201), 32'hCAFE_F00D);

      // Back-to-back loads with req_valid held high throughout
      mem[30'h300] = 32'h0123_4567;
      mem[30'h301] = 32'h89AB_CDEF;
      resp_q.delete();
      a0 = acc_cyc_q.size();
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0C00, 32'h0, 1'b1);
      issue(1'b0, 2'd1, 1'b1, 32'h0000_0C06, 32'h0, 1'b0);
      wait_idle();
      chk("b2b_gap", 32'(acc_cyc_q[a0 + 1] - acc_cyc_q[a0]), 32'(RL + 2));
      chk("b2b_nresp", 32'(resp_q.size()), 32'd2);
      if (resp_q.size() == 2) begin
         chk("b2b_first", resp_q[0], 32'h0123_4567);
         chk("b2b_second", resp_q[1], 32'hFFFF_89AB);
      end

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = 32'h0000_4000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
         if (sz != 2'd3 && $urandom_range(0, 3) != 0)
            a = a & ~((32'd1 << sz) - 32'd1);
         if ($urandom_range(0, 39) == 0) begin
            issue(1'($urandom()), sz, 1'($urandom()), a, $urandom(), 1'b0);
            repeat ($urandom_range(0, RL + 1)) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
         end else begin
            issue(1'($urandom()), sz, 1'($urandom()), a, $urandom(), 1'($urandom()));
            if ($urandom_range(0, 3) == 0) wait_idle();
         end
      end
      req_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
